// File: rtl/cnn_frame_streamer.sv
// cnn_frame_streamer: replays ROM-held frames into the accelerator stream, one dut reset and one result record per frame
module cnn_frame_streamer #(
    parameter int DATA_W = 8,
    parameter int RESULT_W = 32,
    parameter int FRAME_LEN = 884,
    parameter int NUM_FRAMES = 6,
    parameter int RST_CYCLES = 3,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT = 300000,
    localparam int AW = $clog2(NUM_FRAMES * FRAME_LEN),
    localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                mem_rd_en,
    output logic [AW-1:0]       mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                dut_rst_n,
    output logic [DATA_W-1:0]   data_out,
    output logic                valid_out,
    input  logic                ready_in,
    input  logic [RESULT_W-1:0] result_in,
    input  logic                result_valid_in,
    input  logic                warning_in,
    output logic                res_wr_en,
    output logic [FW-1:0]       res_frame_idx,
    output logic [RESULT_W-1:0] res_data,
    output logic                res_warning,
    output logic                res_timeout,
    output logic                busy,
    output logic                done,
    output logic                timeout_err
);
    typedef enum logic [2:0] {IDLE, DUT_RST, STREAM, WAIT_RES, GAP, DONE} state_t;
    localparam int CW = $clog2(TIMEOUT + RST_CYCLES + GAP_CYCLES + 1);
    localparam int RW = $clog2(FRAME_LEN + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_FRAMES * FRAME_LEN - 1);
    state_t state;
    logic [FW-1:0] frame;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rd_cnt, beat_cnt;
    logic [1:0] occ;
    logic [DATA_W-1:0] f1;
    logic [RESULT_W-1:0] lat_data;
    logic rd_pend, pop, last, decide, go_next, res_lat, lat_warn;
    // data_out is the FIFO head; f1 holds the second entry
    assign valid_out = occ != 2'd0;
    assign pop = valid_out && ready_in;
    // a slot freed by this cycle's pop counts as free, which keeps 1 beat/cycle with two entries
    assign mem_rd_en = state == STREAM && rd_cnt != RW'(FRAME_LEN) && (occ + {1'b0, rd_pend} < 2'd2 || pop);
    assign busy = state != IDLE && state != DONE;
    assign done = state == DONE;
    assign last = frame == FW'(NUM_FRAMES - 1);
    assign decide = res_lat || cnt == CW'(TIMEOUT - 1);
    assign go_next = (state == GAP && cnt == CW'(GAP_CYCLES - 1)) || (state == WAIT_RES && decide && GAP_CYCLES == 0);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            frame <= '0;
            cnt <= '0;
            rd_cnt <= '0;
            beat_cnt <= '0;
            mem_addr <= '0;
            rd_pend <= 1'b0;
            occ <= '0;
            data_out <= '0;
            f1 <= '0;
            dut_rst_n <= 1'b0;
            res_lat <= 1'b0;
            lat_data <= '0;
            lat_warn <= 1'b0;
            res_wr_en <= 1'b0;
            res_frame_idx <= '0;
            res_data <= '0;
            res_warning <= 1'b0;
            res_timeout <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            res_wr_en <= 1'b0;
            dut_rst_n <= 1'b1;
            rd_pend <= mem_rd_en;
            occ <= occ + {1'b0, rd_pend} - {1'b0, pop};
            if (pop) data_out <= (rd_pend && occ == 2'd1) ? mem_rdata : f1;
            else if (rd_pend && occ == 2'd0) data_out <= mem_rdata;
            if (rd_pend && occ == (pop ? 2'd2 : 2'd1)) f1 <= mem_rdata;
            if ((state == STREAM || state == WAIT_RES) && result_valid_in && !res_lat) begin
                res_lat <= 1'b1;
                lat_data <= result_in;
                lat_warn <= warning_in;
            end
            if (mem_rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (mem_addr != LAST_ADDR) mem_addr <= mem_addr + 1'b1;
            end
            case (state)
                IDLE, DONE: if (start) begin
                    state <= DUT_RST;
                    frame <= '0;
                    cnt <= '0;
                    mem_addr <= '0;
                    timeout_err <= 1'b0;
                    dut_rst_n <= 1'b0;
                end
                DUT_RST: begin
                    occ <= '0;
                    rd_cnt <= '0;
                    beat_cnt <= '0;
                    res_lat <= 1'b0;
                    cnt <= cnt == CW'(RST_CYCLES - 1) ? '0 : cnt + 1'b1;
                    if (cnt == CW'(RST_CYCLES - 1)) state <= STREAM;
                    else dut_rst_n <= 1'b0;
                end
                STREAM: if (pop) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt == RW'(FRAME_LEN - 1)) state <= WAIT_RES;
                end
                WAIT_RES: if (decide) begin
                    res_wr_en <= 1'b1;
                    res_frame_idx <= frame;
                    res_data <= res_lat ? lat_data : '0;
                    res_warning <= res_lat && lat_warn;
                    res_timeout <= !res_lat;
                    timeout_err <= timeout_err || !res_lat;
                    cnt <= '0;
                    state <= GAP;
                end else cnt <= cnt + 1'b1;
                GAP: cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
            if (go_next) begin
                state <= last ? DONE : DUT_RST;
                if (!last) frame <= frame + 1'b1;
                dut_rst_n <= last;
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cnn_frame_streamer.sv
// tb_cnn_frame_streamer: directed table-driven runs of a 2-frame x 4-sample streamer plus reset corner cases
module tb_cnn_frame_streamer;
    logic clk = 0, rst_n = 0, start = 0, ready_in = 0, result_valid_in = 0, warning_in = 0;
    logic [7:0] mem_rdata = 0, data_out;
    logic [31:0] result_in = 0, res_data;
    logic [2:0] mem_addr;
    logic [0:0] res_frame_idx;
    logic mem_rd_en, dut_rst_n, valid_out, res_wr_en, res_warning, res_timeout, busy, done, timeout_err;
    logic [7:0] rom [8];
    int n_chk = 0, n_err = 0, cyc = 0;
    typedef struct {
        logic [7:0] ready_pat;
        int res_delay;
        logic [31:0] res_val;
        logic warn;
        logic [31:0] mid_val;
        logic mid_warn;
        logic [31:0] exp_data;
        logic exp_warn, exp_to, exp_terr;
        int exp_lat;
    } vec_t;
    typedef struct {int idx; logic [31:0] data; logic warn, to; int cyc;} rec_t;
    vec_t vt[4];
    logic [7:0] bq[$];
    int bc[$], rdq[$], lq[$];
    rec_t rq[$];
    int fbeats = 0, stall_err = 0, lo = 0;
    bit stall_prev = 0;
    logic [7:0] stall_data;

    cnn_frame_streamer #(.DATA_W(8), .RESULT_W(32), .FRAME_LEN(4), .NUM_FRAMES(2),
        .RST_CYCLES(3), .GAP_CYCLES(2), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .dut_rst_n(dut_rst_n), .data_out(data_out), .valid_out(valid_out),
        .ready_in(ready_in), .result_in(result_in), .result_valid_in(result_valid_in),
        .warning_in(warning_in), .res_wr_en(res_wr_en), .res_frame_idx(res_frame_idx),
        .res_data(res_data), .res_warning(res_warning), .res_timeout(res_timeout),
        .busy(busy), .done(done), .timeout_err(timeout_err));

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= rom[mem_addr];
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    // observes the cycle's settled outputs; a beat is counted when valid_out && ready_in
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            fbeats = 0;
            stall_prev = 0;
            lo = 0;
        end else begin
            if (stall_prev && !(valid_out && data_out == stall_data)) stall_err++;
            stall_prev = valid_out && !ready_in;
            stall_data = data_out;
            if (valid_out && ready_in) begin
                bq.push_back(data_out);
                bc.push_back(cyc);
                fbeats++;
            end
            if (mem_rd_en) rdq.push_back(cyc);
            if (res_wr_en) begin
                rq.push_back('{int'(res_frame_idx), res_data, res_warning, res_timeout, cyc});
                fbeats = 0;
            end
            if (!dut_rst_n) lo++;
            else if (lo != 0) begin
                lq.push_back(lo);
                lo = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int c, inout int wait_c, inout bit mid_sent);
        @(posedge clk);
        #1;
        ready_in = v.ready_pat[c % 8];
        result_valid_in = 0;
        result_in = 0;
        warning_in = 0;
        if (fbeats == 0) begin
            wait_c = 0;
            mid_sent = 0;
        end
        if (fbeats == 2 && v.mid_val != 0 && !mid_sent) begin
            result_valid_in = 1;
            result_in = v.mid_val;
            warning_in = v.mid_warn;
            mid_sent = 1;
        end
        if (fbeats == 4) begin
            wait_c++;
            if (wait_c == v.res_delay) begin
                result_valid_in = 1;
                result_in = v.res_val;
                warning_in = v.warn;
            end
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int b0, r0, l0, d0, s0, s, wait_c, errs;
        bit mid_sent;
        string p;
        p = $sformatf("v%0d_", vi);
        b0 = bq.size(); r0 = rq.size(); l0 = lq.size(); d0 = rdq.size(); s0 = stall_err;
        wait_c = 0; mid_sent = 0; s = 0;
        for (int c = 0; c < 400; c++) begin
            step(v, c, wait_c, mid_sent);
            if (c == 0) s = cyc;
            if (c > 0 && done) break;
            // repeated start while busy, including in the record cycle, must be ignored
            start = c == 0 || c == 5 || res_wr_en;
        end
        start = 0;
        chk({p, "done"}, done, 1);
        chk({p, "busy"}, busy, 0);
        chk({p, "timeout_err"}, timeout_err, v.exp_terr);
        chk({p, "beats"}, bq.size() - b0, 8);
        chk({p, "records"}, rq.size() - r0, 2);
        chk({p, "stall_stable"}, stall_err - s0, 0);
        chk({p, "first_rd_lat"}, rdq.size() > d0 ? rdq[d0] - s : -1, 4);
        chk({p, "rst_pulses"}, lq.size() - l0, 2);
        for (int i = l0; i < lq.size(); i++) chk({p, "rst_len"}, lq[i], 3);
        errs = 0;
        for (int i = 0; i < bq.size() - b0; i++) if (bq[b0 + i] !== 8'(i)) errs++;
        chk({p, "beat_order"}, errs, 0);
        if (bq.size() - b0 == 8 && v.ready_pat == 8'hFF) begin
            chk({p, "first_beat_lat"}, bc[b0] - s, 6);
            chk({p, "tput_f0"}, bc[b0 + 3] - bc[b0], 3);
            chk({p, "tput_f1"}, bc[b0 + 7] - bc[b0 + 4], 3);
        end
        for (int f = 0; f < 2 && r0 + f < rq.size(); f++) begin
            chk({p, $sformatf("idx%0d", f)}, rq[r0 + f].idx, f);
            chk({p, $sformatf("data%0d", f)}, rq[r0 + f].data, v.exp_data);
            chk({p, $sformatf("warn%0d", f)}, rq[r0 + f].warn, v.exp_warn);
            chk({p, $sformatf("to%0d", f)}, rq[r0 + f].to, v.exp_to);
            if (bq.size() - b0 == 8) chk({p, $sformatf("lat%0d", f)}, rq[r0 + f].cyc - bc[b0 + 4 * f + 3], v.exp_lat);
        end
    endtask

    initial begin
        int wait_c, r0;
        bit mid_sent;
        for (int i = 0; i < 8; i++) rom[i] = 8'(i);
        vt[0] = '{8'hFF, 10, 32'hA5, 1'b0, 32'h0, 1'b0, 32'hA5, 1'b0, 1'b0, 1'b0, 12};
        vt[1] = '{8'b1011_0010, 5, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 7};
        vt[2] = '{8'hFF, 0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 21};
        vt[3] = '{8'b1110_1101, 1, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 2};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_dut_rst_n", dut_rst_n, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_res_wr_en", res_wr_en, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy_done", {busy, done, timeout_err}, 0);
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_dut_rst_n", dut_rst_n, 1);
        chk("idle_busy", busy, 0);
        for (int i = 0; i < 4; i++) run_vec(i, vt[i]);
        // abort in the middle of frame 1, then replay from frame 0
        r0 = rq.size(); wait_c = 0; mid_sent = 0;
        for (int c = 0; c < 300; c++) begin
            step(vt[0], c, wait_c, mid_sent);
            start = c == 0;
            if (rq.size() - r0 == 1 && fbeats == 2) break;
        end
        start = 0;
        chk("mid_reached", fbeats, 2);
        rst_n = 0;
        @(posedge clk);
        #1;
        chk("abort_mem_rd_en", mem_rd_en, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_dut_rst_n", dut_rst_n, 0);
        chk("abort_valid_out", valid_out, 0);
        chk("abort_data_out", data_out, 0);
        chk("abort_res", {res_wr_en, res_warning, res_timeout, res_frame_idx}, 0);
        chk("abort_res_data", res_data, 0);
        chk("abort_busy_done", {busy, done, timeout_err}, 0);
        rst_n = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_record", rq.size() - r0, 1);
        chk("abort_idle", busy, 0);
        run_vec(4, vt[0]);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
